systolic_mm_array: RTL

- NxN output-stationary systolic matrix-multiply array, directly downstream of the row/column skew (rearrange) stage.
- Consumes one skewed row vector (A operands) and one skewed column vector (B operands) per beat, and accumulates C = A x B in place.
- Presents the full NxN result with a done flag for the writeback/collect stage.

---
 rtl/systolic_pkg.sv | 7 +
 rtl/mac_pe.sv | 35 +++
 rtl/systolic_mm_array.sv | 75 +++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: default sizes and control states for the systolic matrix-multiply array
package systolic_pkg;
  localparam int BW_D = 8;
  localparam int N_D = 5;
  localparam int ACC_W_D = 2*BW_D+$clog2(N_D);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/mac_pe.sv
// mac_pe: one output-stationary PE; forwards a right and b down, accumulates a*b in place
module mac_pe #(
  parameter int BW = 8,
  parameter int ACC_W = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic [BW-1:0] a_in,
  input  logic [BW-1:0] b_in,
  output logic [BW-1:0] a_out,
  output logic [BW-1:0] b_out,
  output logic [ACC_W-1:0] acc
);
  logic [BW-1:0] a_q, b_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2*BW-1:0] prod;
  assign prod = (2*BW)'(a_q) * (2*BW)'(b_q);
  assign acc_d = acc_q + ACC_W'(prod);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else if (en) begin
      a_q <= a_in;
      b_q <= b_in;
      acc_q <= acc_d;
    end
  end
  assign a_out = a_q;
  assign b_out = b_q;
  assign acc = acc_q;
endmodule

// File: rtl/systolic_mm_array.sv
// systolic_mm_array: NxN output-stationary systolic matrix multiply with run/drain/done control
module systolic_mm_array
  import systolic_pkg::*;
#(
  parameter int BW = BW_D,
  parameter int N = N_D,
  parameter int ACC_W = 2*BW+$clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic iStart,
  input  logic iValid,
  input  logic [0:N-1][BW-1:0] iRow,
  input  logic [0:N-1][BW-1:0] iCol,
  output logic [0:N-1][0:N-1][ACC_W-1:0] oResult,
  output logic oBusy,
  output logic oDone
);
  localparam int CW = $clog2(2*N);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run, en, clear;
  logic [BW-1:0] a_w [N][N+1];
  logic [BW-1:0] b_w [N+1][N];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // one counter serves as beat counter in RUN and drain counter in DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      RUN: if (iValid) begin
        state_d = (cnt_q == CW'(2*N-2)) ? DRAIN : RUN;
        cnt_d = (cnt_q == CW'(2*N-2)) ? '0 : cnt_q + 1'b1;
      end
      DRAIN: begin
        state_d = (cnt_q == CW'(N-1)) ? DONE : DRAIN;
        cnt_d = (cnt_q == CW'(N-1)) ? '0 : cnt_q + 1'b1;
      end
      default: if (iStart) begin
        state_d = RUN;
        cnt_d = '0;
      end
    endcase
  end
  assign run = state_q == RUN;
  assign en = (run && iValid) || state_q == DRAIN;
  assign clear = (state_q == IDLE || state_q == DONE) && iStart;
  assign oBusy = run || state_q == DRAIN;
  assign oDone = state_q == DONE;
  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_w[i][0] = run ? iRow[i] : '0;
    assign b_w[0][i] = run ? iCol[i] : '0;
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_pe #(.BW(BW), .ACC_W(ACC_W)) u_pe (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .en(en),
        .a_in(a_w[i][j]),
        .b_in(b_w[i][j]),
        .a_out(a_w[i][j+1]),
        .b_out(b_w[i+1][j]),
        .acc(oResult[i][j])
      );
    end
  end
endmodule
